// File: rtl/gpio_mon_pkg.sv
// ============================================================================
// gpio_mon_pkg : shared FSM encoding and event record for the GPIO monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package gpio_mon_pkg;

  localparam int NUM_CH_DEF   = 34;
  localparam int TS_WIDTH_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_EN = 3'd1,
    ST_RUN     = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  // Event record at the default widths; timestamp occupies the upper bits.
  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0] ts;
    logic [NUM_CH_DEF-1:0]   snap;
  } evt_t;

endpackage

`default_nettype wire

// File: rtl/gpio_mon_fifo.sv
// ============================================================================
// gpio_mon_fifo : synchronous FIFO, wrap-bit pointers, push/pop/clear
// Rev 1.0
// ============================================================================
`default_nettype none

module gpio_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot the simultaneous push needs when full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/gpio_event_monitor.sv
// ============================================================================
// gpio_event_monitor : timestamps GPIO changes into a FIFO, pass/fail watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module gpio_event_monitor
  import gpio_mon_pkg::*;
#(
  parameter int NUM_CH      = 34,
  parameter int TS_WIDTH    = 24,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int RUN_CYC     = 1000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start_i,
  input  logic                       en_i,
  input  logic [NUM_CH-1:0]          ch_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [TS_WIDTH+NUM_CH-1:0] evt_data_o,
  output logic                       overflow_o,
  output logic [2:0]                 state_o,
  output logic                       done_o,
  output logic                       pass_o
);

  localparam int CNT_MAX = (TIMEOUT_CYC > RUN_CYC) ? TIMEOUT_CYC : RUN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYC - 1);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [NUM_CH-1:0]   snap;
  } mon_evt_t;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [NUM_CH-1:0]   prev_q, prev_d;
  logic                ovf_q, ovf_d;
  logic                done_q, pass_q;

  logic     fifo_clear;
  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  mon_evt_t push_evt;

  assign evt_valid_o = !fifo_empty;
  assign fifo_pop    = evt_valid_o && evt_ready_i;
  assign push_evt    = '{ts: ts_q, snap: ch_i};

  gpio_mon_fifo #(
    .WIDTH (TS_WIDTH + NUM_CH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (push_evt),
    .data_o  (evt_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ts_d       = ts_q;
    prev_d     = prev_q;
    ovf_d      = ovf_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start_i) begin
          state_d    = ST_WAIT_EN;
          cnt_d      = '0;
          ts_d       = '0;
          ovf_d      = 1'b0;
          fifo_clear = 1'b1;
        end
      end
      ST_WAIT_EN: begin
        if (en_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          ts_d    = '0;
          prev_d  = ch_i;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAIL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        fifo_push = (ch_i != prev_q);
        prev_d    = ch_i;
        ts_d      = (ts_q == '1) ? ts_q : ts_q + TS_WIDTH'(1);
        if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
        // Verdict includes a drop on the final cycle itself.
        if (cnt_q == RUN_LAST) begin
          state_d = ovf_d ? ST_FAIL : ST_PASS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ts_q    <= '0;
      prev_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      done_q  <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_q  <= (state_d == ST_PASS);
    end
  end

  assign overflow_o = ovf_q;
  assign state_o    = state_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_event_monitor.sv
// ============================================================================
// tb_gpio_event_monitor : scoreboard bench for gpio_event_monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpio_event_monitor;
  import gpio_mon_pkg::*;

  localparam int NUM_CH = 34;
  localparam int TS_W   = 24;
  localparam int EW     = NUM_CH + TS_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              en = 1'b0;
  logic              ready = 1'b0;
  logic [NUM_CH-1:0] ch = '0;

  logic          evt_valid;
  logic [EW-1:0] evt_data;
  logic          overflow;
  logic [2:0]    state;
  logic          done;
  logic          pass;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  bit            valid_seen = 1'b0;
  bit            last_stall = 1'b0;
  logic [EW-1:0] last_data = '0;

  gpio_event_monitor #(
    .NUM_CH      (NUM_CH),
    .TS_WIDTH    (TS_W),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (20),
    .RUN_CYC     (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start),
    .en_i        (en),
    .ch_i        (ch),
    .evt_valid_o (evt_valid),
    .evt_ready_i (ready),
    .evt_data_o  (evt_data),
    .overflow_o  (overflow),
    .state_o     (state),
    .done_o      (done),
    .pass_o      (pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ts, input logic [NUM_CH-1:0] v);
    exp_q.push_back({TS_W'(ts), v});
  endtask

  // Monitor: pops an expected event whenever the DUT hands one over.
  always @(negedge clk) begin
    if (rst) begin
      last_stall = 1'b0;
    end else begin
      if (evt_valid) valid_seen = 1'b1;
      if (last_stall && evt_valid) check("hold_data", 64'(evt_data), 64'(last_data));
      if (evt_valid && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_evt: got %0h, required none", evt_data);
        end else begin
          check("evt", 64'(evt_data), 64'(exp_q.pop_front()));
        end
      end
      last_stall = evt_valid && !ready;
      last_data  = evt_data;
    end
  end

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("enter_wait", 64'(state), 64'(ST_WAIT_EN));
  endtask

  task automatic enter_run();
    ch = '0;
    en = 1'b1;
    tick();
    check("enter_run", 64'(state), 64'(ST_RUN));
  endtask

  task automatic drain(input string name);
    ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_empty"}, 64'(evt_valid), 64'd0);
  endtask

  initial begin
    logic [NUM_CH-1:0] vec [8];

    repeat (3) tick();
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_data", 64'(evt_data), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    rst = 1'b0;
    tick();

    // Constant channels: clean PASS, no events.
    ready = 1'b1;
    valid_seen = 1'b0;
    run_start();
    enter_run();
    repeat (7) tick();
    check("t1_still_run", 64'(state), 64'(ST_RUN));
    tick();
    check("t1_state", 64'(state), 64'(ST_PASS));
    check("t1_done", 64'(done), 64'd1);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_no_evt", 64'(valid_seen), 64'd0);

    // Two changes plus one on the final RUN cycle.
    vec = '{34'h0, 34'h0, 34'h0, 34'h5, 34'h5, 34'h5, 34'h4, 34'h6};
    push_exp(3, 34'h5);
    push_exp(6, 34'h4);
    push_exp(7, 34'h6);
    run_start();
    enter_run();
    for (int i = 0; i < 8; i++) begin
      ch = vec[i];
      if (i == 3) check("t2_not_early", 64'(evt_valid), 64'd0);
      tick();
      if (i == 3 || i == 6 || i == 7) check("t2_latency", 64'(evt_valid), 64'd1);
    end
    check("t2_state", 64'(state), 64'(ST_PASS));
    drain("t2");

    // Overflow: six toggles into a 4-deep FIFO with no consumer.
    ready = 1'b0;
    vec = '{34'h1, 34'h0, 34'h1, 34'h0, 34'h1, 34'h0, 34'h0, 34'h0};
    push_exp(0, 34'h1);
    push_exp(1, 34'h0);
    push_exp(2, 34'h1);
    push_exp(3, 34'h0);
    run_start();
    enter_run();
    for (int i = 0; i < 8; i++) begin
      ch = vec[i];
      tick();
      if (i == 3) check("t3_full_no_ovf", 64'(overflow), 64'd0);
      if (i == 4) check("t3_ovf_set", 64'(overflow), 64'd1);
    end
    check("t3_state", 64'(state), 64'(ST_FAIL));
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_done", 64'(done), 64'd1);
    check("t3_pass", 64'(pass), 64'd0);
    drain("t3");

    // Enable never arrives: FAIL after exactly 20 WAIT_EN cycles.
    en = 1'b0;
    ready = 1'b0;
    run_start();
    check("t4_ovf_cleared", 64'(overflow), 64'd0);
    check("t4_done_cleared", 64'(done), 64'd0);
    repeat (19) tick();
    check("t4_wait19", 64'(state), 64'(ST_WAIT_EN));
    tick();
    check("t4_state", 64'(state), 64'(ST_FAIL));
    check("t4_done", 64'(done), 64'd1);
    check("t4_pass", 64'(pass), 64'd0);

    // Full FIFO, then pop and push in the same cycle.
    vec = '{34'h1, 34'h2, 34'h3, 34'h4, 34'h5, 34'h5, 34'h5, 34'h5};
    push_exp(0, 34'h1);
    push_exp(1, 34'h2);
    push_exp(2, 34'h3);
    push_exp(3, 34'h4);
    push_exp(4, 34'h5);
    run_start();
    enter_run();
    for (int i = 0; i < 8; i++) begin
      ch = vec[i];
      if (i == 4) ready = 1'b1;
      tick();
      if (i == 4) check("t5_no_ovf", 64'(overflow), 64'd0);
    end
    check("t5_state", 64'(state), 64'(ST_PASS));
    check("t5_ovf", 64'(overflow), 64'd0);
    drain("t5");

    // Reset mid-RUN discards buffered events.
    ready = 1'b0;
    run_start();
    enter_run();
    for (int i = 1; i <= 3; i++) begin
      ch = NUM_CH'(i);
      push_exp(i - 1, NUM_CH'(i));
      tick();
    end
    check("t6_buffered", 64'(evt_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("t6_state", 64'(state), 64'(ST_IDLE));
    check("t6_valid", 64'(evt_valid), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    rst = 1'b0;
    en = 1'b0;
    tick();
    check("t6_still_idle", 64'(state), 64'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
